// File: rtl/spi_slave_ctrl_pkg.sv
// rtl/spi_slave_ctrl_pkg.sv - shared types and constants for the SPI slave controller
package spi_slave_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic [1:0] spi_mode_t;

    localparam spi_mode_t MODE0 = 2'd0;
    localparam spi_mode_t MODE1 = 2'd1;
    localparam spi_mode_t MODE2 = 2'd2;
    localparam spi_mode_t MODE3 = 2'd3;

    localparam logic [31:0] DEFAULT_FILL_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/spi_slave_ctrl_fifo.sv
// rtl/spi_slave_ctrl_fifo.sv - synchronous FIFO with combinational head, full/empty/count
module spi_slave_ctrl_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - system-clock sequencer for the word-framed SPI slave
// Optional frame/abort counters: define SPI_SLAVE_CTRL_STATS_EN.
module spi_slave_ctrl
    import spi_slave_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DEFAULT_FILL_WORD
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [1:0]            CfgMode,
    input  logic                  TxValid,
    output logic                  TxReady,
    input  logic [DATA_WIDTH-1:0] TxData,
    output logic                  RxValid,
    input  logic                  RxReady,
    output logic [DATA_WIDTH-1:0] RxData,
    input  logic                  ClrErr,
    output logic                  Busy,
    output logic                  TxUnderflow,
    output logic                  RxOverflow,
    output logic                  FrameAbort,
    output logic [1:0]            SlvMode,
    output logic [DATA_WIDTH-1:0] SlvTxData,
    input  logic [DATA_WIDTH-1:0] SlvRxData,
    input  logic                  SlvDone,
    input  logic                  SS
`ifdef SPI_SLAVE_CTRL_STATS_EN
    ,
    output logic [15:0]           FrameCnt,
    output logic [15:0]           AbortCnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  state_q;
    spi_mode_t               mode_q;
    logic [DATA_WIDTH-1:0]   tx_word_q;
    logic                    tx_armed_q;
    logic                    ss_meta_q, ss_s_q, ss_prev_q, done_q;
    logic                    underflow_q, overflow_q, abort_q;

    logic [DATA_WIDTH-1:0]   tx_head;
    logic                    tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]           tx_count, rx_count;
    logic                    unused_counts;

    logic ss_fall, done_rise, frame_start, frame_done, frame_abort;
    logic tx_push, tx_pop, rx_push, rx_pop;

    assign ss_fall     = ss_prev_q & ~ss_s_q;
    assign done_rise   = SlvDone & ~done_q;
    assign frame_start = (state_q == IDLE) & ss_fall;
    assign frame_done  = (state_q == ACTIVE) & done_rise;
    assign frame_abort = (state_q == ACTIVE) & ss_s_q & ~done_rise;

    assign tx_push = TxValid & ~tx_full;
    assign tx_pop  = frame_done & tx_armed_q;
    assign rx_push = frame_done & ~rx_full;
    assign rx_pop  = RxReady & ~rx_empty;

    assign TxReady     = ~tx_full;
    assign RxValid     = ~rx_empty;
    assign Busy        = (state_q != IDLE);
    assign TxUnderflow = underflow_q;
    assign RxOverflow  = overflow_q;
    assign FrameAbort  = abort_q;
    assign SlvMode     = mode_q;
    assign SlvTxData   = tx_word_q;
    assign unused_counts = ^{tx_count, rx_count};

    spi_slave_ctrl_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(Clk), .rst_n(Rst_n), .push_i(tx_push), .data_i(TxData), .pop_i(tx_pop),
        .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
    );

    spi_slave_ctrl_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(Clk), .rst_n(Rst_n), .push_i(rx_push), .data_i(SlvRxData), .pop_i(rx_pop),
        .data_o(RxData), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
    );

    // SS idles high, so the synchronizer resets high to avoid a phantom frame start.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ss_meta_q <= 1'b1;
            ss_s_q    <= 1'b1;
            ss_prev_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            ss_meta_q <= SS;
            ss_s_q    <= ss_meta_q;
            ss_prev_q <= ss_s_q;
            done_q    <= SlvDone;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE0;
            tx_word_q   <= FILL_WORD;
            tx_armed_q  <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_word_q  <= tx_empty ? FILL_WORD : tx_head;
                    tx_armed_q <= ~tx_empty;
                    mode_q     <= CfgMode;
                    if (ss_fall) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (done_rise)   state_q <= DONE;
                    else if (ss_s_q) state_q <= IDLE;
                end
                DONE: begin
                    if (ss_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A set event in the same cycle as ClrErr takes priority.
            underflow_q <= (frame_start & tx_empty) | (underflow_q & ~ClrErr);
            overflow_q  <= (frame_done & rx_full)   | (overflow_q & ~ClrErr);
            abort_q     <= frame_abort              | (abort_q & ~ClrErr);
        end
    end

`ifdef SPI_SLAVE_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, abort_cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else if (ClrErr) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (frame_done && frame_cnt_q != 16'hFFFF)  frame_cnt_q <= frame_cnt_q + 16'd1;
            if (frame_abort && abort_cnt_q != 16'hFFFF) abort_cnt_q <= abort_cnt_q + 16'd1;
        end
    end

    assign FrameCnt = frame_cnt_q;
    assign AbortCnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - randomized self-checking bench for spi_slave_ctrl
module tb_spi_slave_ctrl;

    localparam logic [31:0] FILL  = 32'hFFFF_FFFF;
    localparam int          DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [1:0]  CfgMode = 2'd0;
    logic        TxValid = 1'b0;
    logic        TxReady;
    logic [31:0] TxData = '0;
    logic        RxValid;
    logic        RxReady = 1'b0;
    logic [31:0] RxData;
    logic        ClrErr = 1'b0;
    logic        Busy;
    logic        TxUnderflow, RxOverflow, FrameAbort;
    logic [1:0]  SlvMode;
    logic [31:0] SlvTxData;
    logic [31:0] SlvRxData = '0;
    logic        SlvDone = 1'b0;
    logic        SS = 1'b1;
`ifdef SPI_SLAVE_CTRL_STATS_EN
    logic [15:0] FrameCnt, AbortCnt;
    int          m_fcnt = 0, m_acnt = 0;
`endif

    spi_slave_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .CfgMode(CfgMode), .TxValid(TxValid), .TxReady(TxReady),
        .TxData(TxData), .RxValid(RxValid), .RxReady(RxReady), .RxData(RxData),
        .ClrErr(ClrErr), .Busy(Busy), .TxUnderflow(TxUnderflow), .RxOverflow(RxOverflow),
        .FrameAbort(FrameAbort), .SlvMode(SlvMode), .SlvTxData(SlvTxData),
        .SlvRxData(SlvRxData), .SlvDone(SlvDone), .SS(SS)
`ifdef SPI_SLAVE_CTRL_STATS_EN
        , .FrameCnt(FrameCnt), .AbortCnt(AbortCnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Reference model: FIFO contents as queues plus sticky flags.
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    bit          m_unf, m_ovf, m_abt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (Busy !== lvl && n < 12) begin
            @(negedge Clk);
            n++;
        end
        check_eq(tag, 32'(Busy), 32'(lvl));
    endtask

    task automatic check_state(input string t);
        check_eq({t, ":tx_ready"}, 32'(TxReady), 32'(tx_q.size() < DEPTH));
        check_eq({t, ":rx_valid"}, 32'(RxValid), 32'(rx_q.size() != 0));
        if (rx_q.size() != 0) check_eq({t, ":rx_data"}, RxData, rx_q[0]);
        check_eq({t, ":busy"}, 32'(Busy), 32'd0);
        check_eq({t, ":unf"}, 32'(TxUnderflow), 32'(m_unf));
        check_eq({t, ":ovf"}, 32'(RxOverflow), 32'(m_ovf));
        check_eq({t, ":abt"}, 32'(FrameAbort), 32'(m_abt));
`ifdef SPI_SLAVE_CTRL_STATS_EN
        check_eq({t, ":fcnt"}, 32'(FrameCnt), 32'(m_fcnt));
        check_eq({t, ":acnt"}, 32'(AbortCnt), 32'(m_acnt));
`endif
    endtask

    task automatic host_push(input logic [31:0] w);
        @(negedge Clk);
        check_eq("push:tx_ready", 32'(TxReady), 32'(tx_q.size() < DEPTH));
        TxValid = 1'b1;
        TxData  = w;
        @(negedge Clk);
        TxValid = 1'b0;
        if (tx_q.size() < DEPTH) tx_q.push_back(w);
    endtask

    task automatic host_pop();
        @(negedge Clk);
        check_eq("pop:rx_valid", 32'(RxValid), 32'(rx_q.size() != 0));
        if (rx_q.size() != 0) check_eq("pop:rx_data", RxData, rx_q[0]);
        RxReady = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0;
        if (rx_q.size() != 0) void'(rx_q.pop_front());
    endtask

    task automatic clear_err();
        @(negedge Clk);
        ClrErr = 1'b1;
        @(negedge Clk);
        ClrErr = 1'b0;
        m_unf = 0; m_ovf = 0; m_abt = 0;
`ifdef SPI_SLAVE_CTRL_STATS_EN
        m_fcnt = 0; m_acnt = 0;
`endif
    endtask

    // One SS-low frame; the master word arrives on Done, or SS rises early when !complete.
    task automatic run_frame(input logic [31:0] mword, input bit complete, input logic [1:0] mid_mode);
        logic [31:0] exp_tx;
        logic [1:0]  exp_mode;
        bit          armed;
        armed    = (tx_q.size() != 0);
        exp_tx   = armed ? tx_q[0] : FILL;
        exp_mode = CfgMode;
        repeat (2) @(negedge Clk);
        SS = 1'b0;
        wait_busy(1'b1, "frame:start");
        check_eq("frame:slv_tx", SlvTxData, exp_tx);
        check_eq("frame:slv_mode", 32'(SlvMode), 32'(exp_mode));
        if (!armed) m_unf = 1;
        CfgMode = mid_mode;
        repeat ($urandom_range(1, 4)) @(negedge Clk);
        check_eq("frame:mode_frozen", 32'(SlvMode), 32'(exp_mode));
        if (complete) begin
            SlvRxData = mword;
            SlvDone   = 1'b1;
            @(negedge Clk);
            SlvDone   = 1'b0;
            SlvRxData = ~mword;
            @(negedge Clk);
            SlvDone   = 1'b1;
            @(negedge Clk);
            SlvDone   = 1'b0;
            check_eq("frame:tx_frozen", SlvTxData, exp_tx);
            if (rx_q.size() < DEPTH) rx_q.push_back(mword);
            else m_ovf = 1;
            if (armed) void'(tx_q.pop_front());
`ifdef SPI_SLAVE_CTRL_STATS_EN
            m_fcnt++;
`endif
        end else begin
            m_abt = 1;
`ifdef SPI_SLAVE_CTRL_STATS_EN
            m_acnt++;
`endif
        end
        SS = 1'b1;
        wait_busy(1'b0, "frame:end");
        @(negedge Clk);
        check_eq("idle:slv_mode", 32'(SlvMode), 32'(mid_mode));
        check_eq("idle:slv_tx", SlvTxData, (tx_q.size() != 0) ? tx_q[0] : FILL);
        check_state("frame");
    endtask

    initial begin
        logic [31:0] w;
        repeat (3) @(negedge Clk);
        check_state("reset");
        check_eq("reset:slv_mode", 32'(SlvMode), 32'd0);
        check_eq("reset:slv_tx", SlvTxData, FILL);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Latency into an empty TX FIFO, then a basic mode-0 frame.
        TxValid = 1'b1;
        TxData  = 32'hA5A5_0001;
        @(negedge Clk);
        TxValid = 1'b0;
        tx_q.push_back(32'hA5A5_0001);
        check_eq("lat:before", SlvTxData, FILL);
        @(negedge Clk);
        check_eq("lat:after", SlvTxData, 32'hA5A5_0001);
        run_frame(32'h1234_5678, 1'b1, 2'd0);
        host_pop();

        // Empty TX -> fill word and underflow.
        run_frame(32'h0BAD_F00D, 1'b1, 2'd0);
        host_pop();
        clear_err();
        check_state("clr1");

        // Five frames with no host reads overflow a 4-deep RX FIFO.
        for (int i = 0; i < 5; i++) begin
            w = $urandom;
            host_push(~w);
            run_frame(w, 1'b1, 2'd0);
        end
        for (int i = 0; i < 4; i++) host_pop();
        check_state("ovf_drain");
        clear_err();

        // Abort keeps the TX head for the next frame.
        w = $urandom;
        host_push(w);
        run_frame(32'h1111_2222, 1'b0, 2'd0);
        run_frame(32'h3333_4444, 1'b1, 2'd0);
        host_pop();
        clear_err();

        // Mode change requested mid-frame takes effect only back in IDLE.
        host_push(32'hC0DE_0003);
        run_frame(32'h5555_6666, 1'b1, 2'd3);
        host_push(32'hC0DE_0004);
        run_frame(32'h7777_8888, 1'b1, 2'd3);
        host_pop();
        host_pop();

        // Fill TX to full and attempt one extra push.
        for (int i = 0; i < DEPTH + 1; i++) host_push($urandom);
        check_state("tx_full");

        // Randomized mix of host and frame activity.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    host_push($urandom);
                2:       host_pop();
                3:       run_frame($urandom, 1'b1, 2'($urandom_range(0, 3)));
                4:       run_frame($urandom, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
                default: clear_err();
            endcase
        end
        while (rx_q.size() != 0) host_pop();
        while (tx_q.size() != 0) run_frame($urandom, 1'b1, 2'd0);
        while (rx_q.size() != 0) host_pop();
        clear_err();
        check_state("mix_end");

        // ClrErr held across an underflow frame start: the set wins for that cycle.
        @(negedge Clk);
        ClrErr = 1'b1;
        SS     = 1'b0;
        wait_busy(1'b1, "clr:start");
        check_eq("clr:set_wins", 32'(TxUnderflow), 32'd1);
        @(negedge Clk);
        check_eq("clr:cleared", 32'(TxUnderflow), 32'd0);
        ClrErr    = 1'b0;
        SlvRxData = 32'hDEAD_BEEF;
        SlvDone   = 1'b1;
        @(negedge Clk);
        SlvDone = 1'b0;
        SS      = 1'b1;
        rx_q.push_back(32'hDEAD_BEEF);
`ifdef SPI_SLAVE_CTRL_STATS_EN
        m_fcnt = 1; m_acnt = 0;
`endif
        wait_busy(1'b0, "clr:end");
        check_state("clr_hold");
        host_pop();

        // Asynchronous reset mid-frame with two TX words queued.
        host_push(32'h0000_00A1);
        host_push(32'h0000_00A2);
        repeat (2) @(negedge Clk);
        SS = 1'b0;
        wait_busy(1'b1, "rst:start");
        #3;
        Rst_n = 1'b0;
        SS    = 1'b1;
        #1;
        tx_q.delete();
        rx_q.delete();
        m_unf = 0; m_ovf = 0; m_abt = 0;
`ifdef SPI_SLAVE_CTRL_STATS_EN
        m_fcnt = 0; m_acnt = 0;
`endif
        check_state("rst_async");
        check_eq("rst:slv_tx", SlvTxData, FILL);
        check_eq("rst:slv_mode", 32'(SlvMode), 32'd0);
        CfgMode = 2'd0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        run_frame(32'h600D_0001, 1'b1, 2'd0);
        host_pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
System-clock controller that sequences the team's word-framed SPI slave: one DATA_WIDTH word per SS-low frame.
- Buffers transmit words in a TX FIFO and presents the head to the slave's TxData before each frame.
- Captures the slave's RxData into an RX FIFO on the rising edge of Done.
- Owns the slave's MODE, which changes only between frames.
- Flags underflow, overflow and aborted frames to the host.

Parameters:
DATA_WIDTH, 32, word width; matches the slave.
FIFO_DEPTH, 4, entries per TX/RX FIFO; power of 2, ≥2.
FILL_WORD, 32'hFFFF_FFFF, word sent when the TX FIFO is empty at frame start.

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
CfgMode  in  2  requested SPI mode
TxValid  in  1  host write strobe
TxReady  out  1  TX FIFO not full
TxData  in  DATA_WIDTH  word to transmit
RxValid  out  1  RX FIFO not empty
RxReady  in  1  host read acknowledge
RxData  out  DATA_WIDTH  RX FIFO head
ClrErr  in  1  clears sticky error flags
Busy  out  1  frame in progress (state != IDLE)
TxUnderflow  out  1  sticky
RxOverflow  out  1  sticky
FrameAbort  out  1  sticky; SS rose before Done
SlvMode  out  2  to slave MODE
SlvTxData  out  DATA_WIDTH  to slave TxData
SlvRxData  in  DATA_WIDTH  from slave RxData
SlvDone  in  1  from slave Done
SS  in  1  raw slave select (async)

Behaviour:
- Reset values: all FIFOs empty; TxReady=1; RxValid=0; Busy=0; all sticky flags 0; SlvMode=0; SlvTxData=FILL_WORD; state IDLE.
- SS passes through a 2-flop synchronizer to give ss_s. SlvDone is Clk-synchronous and is used directly. done_rise = SlvDone & ~done_q.
- FIFOs use valid/ready semantics: TX pushes on TxValid&TxReady; RX pops on RxValid&RxReady.
- RxData shows the RX head combinationally from FIFO storage.
- Push and pop in the same cycle are legal at any fill level except push to a full FIFO.
- FSM:
  - IDLE:
    - Each cycle, SlvTxData <= TX head if non-empty, else FILL_WORD; tx_armed <= non-empty.
    - SlvMode <= CfgMode.
    - ss_s falling -> ACTIVE.
    - If tx_armed=0 on entry to ACTIVE, set TxUnderflow.
  - ACTIVE:
    - done_rise -> DONE. In that cycle:
      - Push SlvRxData to RX. If RX is full, drop the word and set RxOverflow.
      - If tx_armed, pop TX.
    - ss_s high with no done_rise -> IDLE: set FrameAbort; no push, no pop.
    - If done_rise and ss_s high occur in the same cycle, done_rise wins: DONE actions, then IDLE next cycle.
  - DONE:
    - ss_s high -> IDLE.
    - Any further SlvDone activity is ignored.
- SlvTxData and SlvMode are frozen outside IDLE.
- The host must not push into an empty TX FIFO within 3 Clk of SS falling; otherwise the TxUnderflow indication is undefined.
- ClrErr clears all sticky flags. If a set event occurs in the same cycle, set wins.
- Host-to-slave latency: a word pushed into an empty FIFO reaches SlvTxData 1 cycle later when in IDLE.

Optional Feature:
SPI_SLAVE_CTRL_STATS_EN
- With the macro defined:
  - Extra outputs FrameCnt[15:0] and AbortCnt[15:0], reset to 0.
  - FrameCnt increments on each done_rise; AbortCnt increments on each ACTIVE->IDLE abort.
  - Both saturate at 16'hFFFF and are cleared by ClrErr.
- Without it: ports and logic are absent.

Decomposition:
- Package spi_slave_ctrl_pkg holds:
  - state enum (IDLE, ACTIVE, DONE)
  - spi_mode_t (2-bit)
  - MODE0..MODE3 constants
  - DEFAULT_FILL_WORD
- Sub-module spi_slave_ctrl_fifo: synchronous FIFO parameterized by width and depth, with full, empty and count outputs; instantiated for TX and RX.

Test Plan:
- Push 32'hA5A5_0001; run a mode-0 frame with master sending 32'h1234_5678 -> slave shifts out A5A5_0001; RxData=1234_5678 with RxValid=1; TX FIFO empty; no flags.
- TX FIFO empty; run a frame -> master receives FFFF_FFFF; TxUnderflow=1; TX pointers unchanged; ClrErr -> 0.
- 5 back-to-back frames, no RxReady, FIFO_DEPTH=4 -> first 4 words held; 5th dropped; RxOverflow=1; RxValid=1.
- Raise SS after 10 bits -> FrameAbort=1; no RX push; TX head still presented; next full frame sends the same word.
- Change CfgMode 0->3 during an active frame -> SlvMode stays 0 until return to IDLE, then 3; a mode-3 frame passes data correctly.
- Assert Rst_n=0 mid-frame with 2 words in TX -> all outputs at reset values immediately, FIFOs empty; with STATS_EN, counters 0.
